// File: rtl/seg_disp_sched.sv
// seg_disp_sched: picks time, edit (blinking digit) or message overlay for the 6-digit display; message > edit > time.
module seg_disp_sched #(
  parameter logic [25:0] MAX_NUM     = 26'd500_000,
  parameter logic [7:0]  BLINK_TICKS = 8'd50,
  parameter logic [9:0]  MSG_TICKS   = 10'd200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] time_data,
  input  logic        edit_en,
  input  logic [23:0] edit_data,
  input  logic [2:0]  edit_pos,
  input  logic        msg_req,
  input  logic [23:0] msg_data,
  output logic [23:0] disp_data,
  output logic [5:0]  disp_en,
  output logic [1:0]  disp_src,
  output logic        msg_busy
);
  typedef enum logic [1:0] {S_TIME = 2'd0, S_EDIT = 2'd1, S_MSG = 2'd2} state_t;
  state_t      state, state_nxt;
  logic [25:0] tick_cnt;
  logic [7:0]  blink_cnt, blink_nxt;
  logic [9:0]  msg_cnt;
  logic [2:0]  pos_q;
  logic [23:0] msg_word, msg_nxt;
  logic        phase_off, off_nxt, tick, msg_done, blink_rst, blink_wrap;
  assign tick       = tick_cnt == MAX_NUM - 26'd1;
  assign msg_done   = tick && msg_cnt == MSG_TICKS - 10'd1;
  assign blink_wrap = blink_cnt == BLINK_TICKS - 8'd1;
  assign msg_nxt    = msg_req ? msg_data : msg_word;
  assign blink_rst  = (state_nxt == S_EDIT && state != S_EDIT) || edit_pos != pos_q;
  always_comb begin
    state_nxt = msg_req ? S_MSG : (state == S_MSG && !msg_done) ? S_MSG : edit_en ? S_EDIT : S_TIME;
    blink_nxt = blink_cnt;
    off_nxt   = phase_off;
    if (blink_rst) begin
      blink_nxt = '0;
      off_nxt   = 1'b0;
    end else if (state == S_EDIT && tick) begin
      blink_nxt = blink_wrap ? 8'd0 : blink_cnt + 8'd1;
      off_nxt   = blink_wrap ? ~phase_off : phase_off;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_TIME;
      tick_cnt  <= '0;
      blink_cnt <= '0;
      msg_cnt   <= '0;
      phase_off <= 1'b0;
      pos_q     <= '0;
      msg_word  <= '0;
      disp_data <= '0;
      disp_en   <= 6'h3F;
      disp_src  <= 2'd0;
      msg_busy  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick ? 26'd0 : tick_cnt + 26'd1;
      blink_cnt <= blink_nxt;
      phase_off <= off_nxt;
      pos_q     <= edit_pos;
      msg_word  <= msg_nxt;
      msg_cnt   <= msg_req ? 10'd0 : (state == S_MSG && tick) ? (msg_done ? 10'd0 : msg_cnt + 10'd1) : msg_cnt;
      // outputs follow the next state so a change is visible exactly one clock after its cause
      disp_data <= state_nxt == S_MSG ? msg_nxt : state_nxt == S_EDIT ? edit_data : time_data;
      disp_en   <= (state_nxt == S_EDIT && off_nxt && edit_pos <= 3'd5) ? ~(6'd1 << edit_pos) : 6'h3F;
      disp_src  <= state_nxt;
      msg_busy  <= state_nxt == S_MSG;
    end
  end
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: random and directed stimulus checked against a tick-counting reference model.
module tb_seg_disp_sched;
  localparam int MN = 4, BT = 2, MT = 3;
  localparam int M_TIME = 0, M_EDIT = 1, M_MSG = 2;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [23:0] time_data = '0, edit_data = '0, msg_data = '0;
  logic        edit_en = 1'b0, msg_req = 1'b0;
  logic [2:0]  edit_pos = '0;
  logic [23:0] disp_data;
  logic [5:0]  disp_en;
  logic [1:0]  disp_src;
  logic        msg_busy;
  seg_disp_sched #(.MAX_NUM(26'(MN)), .BLINK_TICKS(8'(BT)), .MSG_TICKS(10'(MT))) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .time_data(time_data), .edit_en(edit_en),
    .edit_data(edit_data), .edit_pos(edit_pos), .msg_req(msg_req), .msg_data(msg_data),
    .disp_data(disp_data), .disp_en(disp_en), .disp_src(disp_src), .msg_busy(msg_busy));
  always #5 sys_clk = ~sys_clk;
  int n_tests = 0, n_fail = 0;
  int m_cyc, m_left, m_bt, m_st;
  logic [2:0]  m_pos;
  logic [23:0] m_word, e_data;
  logic [5:0]  e_en;
  logic [1:0]  e_src;
  logic        e_busy;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_cyc = 0; m_left = 0; m_bt = 0; m_st = M_TIME; m_pos = '0; m_word = '0;
    e_data = '0; e_en = 6'h3F; e_src = 2'd0; e_busy = 1'b0;
  endtask
  // advances the model by the clock edge that is about to sample the current inputs
  task automatic model_update();
    bit tk, on;
    int prev;
    tk = (m_cyc % MN) == MN - 1;
    m_cyc++;
    prev = m_st;
    if (m_st == M_EDIT && tk) m_bt++;
    if (msg_req) begin
      m_st = M_MSG; m_word = msg_data; m_left = MT;
    end else if (m_st == M_MSG) begin
      if (tk) m_left--;
      if (m_left == 0) m_st = edit_en ? M_EDIT : M_TIME;
    end else m_st = edit_en ? M_EDIT : M_TIME;
    if ((m_st == M_EDIT && prev != M_EDIT) || edit_pos != m_pos) m_bt = 0;
    m_pos = edit_pos;
    on = ((m_bt / BT) % 2) == 0;
    e_src  = 2'(m_st);
    e_busy = m_st == M_MSG;
    e_data = m_st == M_MSG ? m_word : m_st == M_EDIT ? edit_data : time_data;
    e_en   = 6'h3F;
    if (m_st == M_EDIT && !on && edit_pos < 3'd6) e_en[edit_pos] = 1'b0;
  endtask
  task automatic compare_all();
    check("disp_data", 32'(disp_data), 32'(e_data));
    check("disp_en", 32'(disp_en), 32'(e_en));
    check("disp_src", 32'(disp_src), 32'(e_src));
    check("msg_busy", 32'(msg_busy), 32'(e_busy));
  endtask
  task automatic step();
    model_update();
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare_all();
  endtask
  task automatic rand_inputs();
    time_data = 24'($urandom);
    edit_data = 24'($urandom);
    msg_data  = 24'($urandom);
    if ($urandom_range(29) == 0) edit_en = ~edit_en;
    if ($urandom_range(14) == 0) edit_pos = 3'($urandom);
    msg_req = $urandom_range(24) == 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge sys_clk);
    compare_all();
    sys_rst_n = 1'b1;
    time_data = 24'h123456;
    repeat (3) step();
    edit_en = 1'b1; edit_data = 24'h120000; edit_pos = 3'd2;
    repeat (20) step();
    edit_pos = 3'd5;
    repeat (20) step();
    msg_req = 1'b1; msg_data = 24'hAAAAAA;
    step();
    msg_req = 1'b0;
    repeat (6) step();
    msg_req = 1'b1; msg_data = 24'h555555;
    step();
    msg_req = 1'b0;
    repeat (10) step();
    msg_req = 1'b1; msg_data = 24'h777777;
    step();
    msg_req = 1'b0;
    repeat (20) step();
    edit_en = 1'b0;
    repeat (5) step();
    repeat (1500) begin
      rand_inputs();
      step();
    end
    msg_req = 1'b1; msg_data = 24'hC0FFEE;
    step();
    msg_req = 1'b0;
    repeat (3) step();
    #2 sys_rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge sys_clk);
    compare_all();
    sys_rst_n = 1'b1;
    repeat (400) begin
      rand_inputs();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
